// File: rtl/connect_four_pkg.sv
// rtl/connect_four_pkg.sv - board geometry, cell/state types and win-run helpers
package connect_four_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int CELLS = ROWS * COLS;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        VALIDATED = 2'b01,
        ROW_READY = 2'b10
    } dp_state_t;

    localparam logic [1:0] PLAYER_1 = 2'b01;
    localparam logic [1:0] PLAYER_2 = 2'b10;

    // Flat board, 2 bits per cell at (row*COLS+col)*2, row 0 at the bottom
    typedef logic [CELLS*2-1:0] board_t;

    function automatic int cell_idx(input logic [2:0] row, input logic [2:0] col);
        return (int'(row) * COLS + int'(col)) * 2;
    endfunction

    // Count same-player cells stepping away from (row,col); stops at the edge or a gap, max 3
    function automatic logic [1:0] dir_run(input board_t board, input logic [2:0] row,
                                           input logic [2:0] col, input int dr, input int dc,
                                           input logic [1:0] player);
        logic [1:0] n;
        logic       go;
        int         r;
        int         c;
        n  = 2'd0;
        go = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            r = int'(row) + dr * k;
            c = int'(col) + dc * k;
            if (go) begin
                if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
                    if (board[(r * COLS + c) * 2 +: 2] == player) n = n + 2'd1;
                    else go = 1'b0;
                end else begin
                    go = 1'b0;
                end
            end
        end
        return n;
    endfunction

    // The placed cell plus both opposing runs reaching four
    function automatic logic line_hit(input logic [1:0] a, input logic [1:0] b);
        return ({1'b0, a} + {1'b0, b}) >= 3'd3;
    endfunction

endpackage

// File: rtl/connect_four_datapath_if.sv
// rtl/connect_four_datapath_if.sv - strobe/status bundle between controller and datapath
interface connect_four_datapath_if;
    import connect_four_pkg::*;

    logic       clear_board;
    logic       validate_enable;
    logic       find_row_enable;
    logic       drop_token;
    logic       switch_player_enable;
    logic       update_display;
    logic       move_left_edge;
    logic       move_right_edge;
    logic       column_full;
    logic       win_found;
    logic       board_full;
    logic [1:0] current_player;
    logic [2:0] cursor_col;
    board_t     disp_cells;

    modport master (
        output clear_board, validate_enable, find_row_enable, drop_token,
               switch_player_enable, update_display, move_left_edge, move_right_edge,
        input  column_full, win_found, board_full, current_player, cursor_col, disp_cells
    );

    modport slave (
        input  clear_board, validate_enable, find_row_enable, drop_token,
               switch_player_enable, update_display, move_left_edge, move_right_edge,
        output column_full, win_found, board_full, current_player, cursor_col, disp_cells
    );
endinterface

// File: rtl/connect_four_win_check.sv
// rtl/connect_four_win_check.sv - combinational four-in-line test around one cell (diagonals under CONNECT_FOUR_DIAG_WIN_EN)
module connect_four_win_check
    import connect_four_pkg::*;
(
    input  board_t     board,
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  logic [1:0] player,
    output logic       win
);

    // Runs are taken on the board before the token lands; the target cell itself is empty
    always_comb begin
        win = line_hit(dir_run(board, row, col, 0, 1, player), dir_run(board, row, col, 0, -1, player))
            | line_hit(dir_run(board, row, col, 1, 0, player), dir_run(board, row, col, -1, 0, player));
`ifdef CONNECT_FOUR_DIAG_WIN_EN
        win = win
            | line_hit(dir_run(board, row, col, 1, 1, player), dir_run(board, row, col, -1, -1, player))
            | line_hit(dir_run(board, row, col, 1, -1, player), dir_run(board, row, col, -1, 1, player));
`else
        win = win;
`endif
    end

endmodule

// File: rtl/connect_four_datapath.sv
// rtl/connect_four_datapath.sv - connect-four board, move sequencer, cursor and display snapshot (CONNECT_FOUR_DIAG_WIN_EN adds diagonal wins)
module connect_four_datapath
    import connect_four_pkg::*;
(
    input  logic              clk,
    input  logic              reset_edge,
    connect_four_datapath_if.slave bus
);

    board_t                board;
    logic [COLS-1:0][2:0]  height;
    logic [5:0]            pieces;
    logic [2:0]            target_col;
    logic [2:0]            target_row;
    dp_state_t             state;
    logic                  column_full_r;
    logic                  win_found_r;
    logic                  board_full_r;
    logic [1:0]            player_r;
    logic [2:0]            cursor_r;
    board_t                disp_r;
    logic                  win_now;

    connect_four_win_check u_win_check (
        .board  (board),
        .row    (target_row),
        .col    (target_col),
        .player (player_r),
        .win    (win_now)
    );

    // Move FSM plus all board/player/cursor/display state; clear_board outranks every strobe
    always_ff @(posedge clk or posedge reset_edge) begin
        if (reset_edge) begin
            board         <= '0;
            height        <= '0;
            pieces        <= 6'd0;
            target_col    <= 3'd0;
            target_row    <= 3'd0;
            state         <= IDLE;
            column_full_r <= 1'b0;
            win_found_r   <= 1'b0;
            board_full_r  <= 1'b0;
            player_r      <= PLAYER_1;
            cursor_r      <= 3'd3;
            disp_r        <= '0;
        end else if (bus.clear_board) begin
            board         <= '0;
            height        <= '0;
            pieces        <= 6'd0;
            target_col    <= 3'd0;
            target_row    <= 3'd0;
            state         <= IDLE;
            column_full_r <= 1'b0;
            win_found_r   <= 1'b0;
            board_full_r  <= 1'b0;
            player_r      <= PLAYER_1;
            cursor_r      <= 3'd3;
        end else begin
            if (bus.update_display) disp_r <= board;

            if (bus.drop_token && state == ROW_READY) begin
                board[cell_idx(target_row, target_col) +: 2] <= player_r;
                height[target_col] <= height[target_col] + 3'd1;
                pieces             <= pieces + 6'd1;
                win_found_r        <= win_found_r | win_now;
                board_full_r       <= board_full_r | (pieces == 6'd41);
                state              <= IDLE;
            end else if (bus.find_row_enable && state == VALIDATED) begin
                target_row <= height[target_col];
                state      <= ROW_READY;
            end else if (bus.validate_enable) begin
                target_col    <= cursor_r;
                column_full_r <= (height[cursor_r] == 3'd6);
                state         <= (height[cursor_r] == 3'd6) ? IDLE : VALIDATED;
            end

            // A decided game freezes whose turn it is
            if (bus.switch_player_enable && !win_found_r)
                player_r <= (player_r == PLAYER_1) ? PLAYER_2 : PLAYER_1;

            // Cursor frozen once the game is over or when both edges collide
            if (!(win_found_r || board_full_r) && (bus.move_left_edge != bus.move_right_edge)) begin
                if (bus.move_left_edge && cursor_r != 3'd0)
                    cursor_r <= cursor_r - 3'd1;
                else if (bus.move_right_edge && cursor_r != 3'd6)
                    cursor_r <= cursor_r + 3'd1;
            end
        end
    end

    assign bus.column_full    = column_full_r;
    assign bus.win_found      = win_found_r;
    assign bus.board_full     = board_full_r;
    assign bus.current_player = player_r;
    assign bus.cursor_col     = cursor_r;
    assign bus.disp_cells     = disp_r;

endmodule

// File: tb/tb_connect_four_datapath.sv
// tb/tb_connect_four_datapath.sv - directed game scenarios checked against a window-scan board model
module tb_connect_four_datapath;

    localparam int S_CLR = 0, S_VAL = 1, S_FIND = 2, S_DROP = 3;
    localparam int S_SW = 4, S_UPD = 5, S_LEFT = 6, S_RIGHT = 7;

    logic clk = 1'b0;
    logic reset_edge;
    always #5 clk = ~clk;

    connect_four_datapath_if bus();

    connect_four_datapath dut (
        .clk        (clk),
        .reset_edge (reset_edge),
        .bus        (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model of the game state
    int          mb [6][7];
    int          mh [7];
    int          mpieces, mstate, mtc, mtr, mplayer, mcursor;
    bit          mcf, mwin, mfull;
    logic [83:0] mdisp;

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [83:0] pack_board();
        logic [83:0] v;
        v = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                v[(r * 7 + c) * 2 +: 2] = 2'(mb[r][c]);
        return v;
    endfunction

    // Any length-4 window in an allowed direction that contains (r,c) and is all p
    function automatic bit window_win(input int r, input int c, input int p);
        int ndir;
        int drs [4];
        int dcs [4];
        bit all_p;
        int rr, cc;
        drs = '{0, 1, 1, 1};
        dcs = '{1, 0, 1, -1};
`ifdef CONNECT_FOUR_DIAG_WIN_EN
        ndir = 4;
`else
        ndir = 2;
`endif
        for (int d = 0; d < ndir; d++)
            for (int s = -3; s <= 0; s++) begin
                all_p = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    rr = r + (s + k) * drs[d];
                    cc = c + (s + k) * dcs[d];
                    if (rr < 0 || rr > 5 || cc < 0 || cc > 6) all_p = 1'b0;
                    else if (mb[rr][cc] != p) all_p = 1'b0;
                end
                if (all_p) return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic model_clear(input bit with_disp);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) mb[r][c] = 0;
        for (int c = 0; c < 7; c++) mh[c] = 0;
        mpieces = 0; mstate = 0; mtc = 0; mtr = 0;
        mplayer = 1; mcursor = 3;
        mcf = 0; mwin = 0; mfull = 0;
        if (with_disp) mdisp = '0;
    endtask

    task automatic model_step(input logic [7:0] s);
        bit old_win, old_full;
        if (s[S_CLR]) begin
            model_clear(1'b0);
            return;
        end
        old_win  = mwin;
        old_full = mfull;
        if (s[S_UPD]) mdisp = pack_board();
        if (s[S_DROP] && mstate == 2) begin
            mb[mtr][mtc] = mplayer;
            mh[mtc]++;
            mpieces++;
            if (window_win(mtr, mtc, mplayer)) mwin = 1;
            if (mpieces == 42) mfull = 1;
            mstate = 0;
        end else if (s[S_FIND] && mstate == 1) begin
            mtr = mh[mtc];
            mstate = 2;
        end else if (s[S_VAL]) begin
            mtc = mcursor;
            mcf = (mh[mcursor] == 6);
            mstate = mcf ? 0 : 1;
        end
        if (s[S_SW] && !old_win) mplayer = (mplayer == 1) ? 2 : 1;
        if (!(old_win || old_full) && (s[S_LEFT] != s[S_RIGHT])) begin
            if (s[S_LEFT] && mcursor > 0) mcursor--;
            else if (s[S_RIGHT] && mcursor < 6) mcursor++;
        end
    endtask

    task automatic set_inputs(input logic [7:0] s);
        bus.clear_board          = s[S_CLR];
        bus.validate_enable      = s[S_VAL];
        bus.find_row_enable      = s[S_FIND];
        bus.drop_token           = s[S_DROP];
        bus.switch_player_enable = s[S_SW];
        bus.update_display       = s[S_UPD];
        bus.move_left_edge       = s[S_LEFT];
        bus.move_right_edge      = s[S_RIGHT];
    endtask

    // One clock with the given strobes; returns 1 time unit after the edge
    task automatic tick(input logic [7:0] s);
        set_inputs(s);
        @(posedge clk);
        model_step(s);
        #1;
        set_inputs(8'h00);
    endtask

    task automatic move_to(input int col);
        for (int i = 0; i < 8 && mcursor != col; i++)
            tick(mcursor < col ? 8'(1 << S_RIGHT) : 8'(1 << S_LEFT));
    endtask

    task automatic play(input int col, input int p);
        move_to(col);
        if (mplayer != p) tick(8'(1 << S_SW));
        tick(8'(1 << S_VAL));
        tick(8'(1 << S_FIND));
        tick(8'(1 << S_DROP));
    endtask

    // Every cycle: DUT outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            check("column_full", 84'(bus.column_full), 84'(mcf));
            check("win_found", 84'(bus.win_found), 84'(mwin));
            check("board_full", 84'(bus.board_full), 84'(mfull));
            check("current_player", 84'(bus.current_player), 84'(mplayer));
            check("cursor_col", 84'(bus.cursor_col), 84'(mcursor));
            check("disp_cells", bus.disp_cells, mdisp);
        end
    end

    initial begin
        int dcols [13];
        logic [83:0] v;
        dcols = '{0, 1, 1, 2, 6, 2, 2, 3, 6, 3, 5, 3, 3};

        set_inputs(8'h00);
        reset_edge = 1'b1;
        model_clear(1'b1);
        #1;
        check("rst_cursor", 84'(bus.cursor_col), 84'd3);
        check("rst_player", 84'(bus.current_player), 84'd1);
        check("rst_disp", bus.disp_cells, 84'd0);
        check("rst_win", 84'(bus.win_found), 84'd0);
        @(posedge clk);
        #1;
        reset_edge = 1'b0;

        // Cursor saturation and collision
        repeat (4) tick(8'(1 << S_LEFT));
        check("cursor_sat_lo", 84'(bus.cursor_col), 84'd0);
        repeat (8) tick(8'(1 << S_RIGHT));
        check("cursor_sat_hi", 84'(bus.cursor_col), 84'd6);
        tick(8'((1 << S_LEFT) | (1 << S_RIGHT)));
        check("cursor_both", 84'(bus.cursor_col), 84'd6);
        tick(8'(1 << S_SW));
        check("switch_p2", 84'(bus.current_player), 84'd2);
        tick(8'((1 << S_CLR) | (1 << S_LEFT) | (1 << S_SW) | (1 << S_UPD)));
        check("clr_prio_cursor", 84'(bus.cursor_col), 84'd3);
        check("clr_prio_player", 84'(bus.current_player), 84'd1);

        // Four alternating drops into column 3
        for (int i = 0; i < 4; i++) begin
            tick(8'(1 << S_VAL));
            tick(8'(1 << S_FIND));
            tick(8'(1 << S_DROP));
            tick(8'(1 << S_SW));
        end
        tick(8'(1 << S_UPD));
        v = bus.disp_cells;
        check("col3_r0", 84'(v[6 +: 2]), 84'd1);
        check("col3_r1", 84'(v[20 +: 2]), 84'd2);
        check("col3_r2", 84'(v[34 +: 2]), 84'd1);
        check("col3_r3", 84'(v[48 +: 2]), 84'd2);
        check("col3_nowin", 84'(bus.win_found), 84'd0);
        play(3, 1);
        tick(8'(1 << S_UPD));
        v = bus.disp_cells;
        check("col3_r4", 84'(v[62 +: 2]), 84'd1);

        // Horizontal win on row 0
        tick(8'(1 << S_CLR));
        play(0, 1); play(0, 2); play(1, 1); play(1, 2); play(2, 1); play(2, 2);
        check("h_prewin", 84'(bus.win_found), 84'd0);
        play(3, 1);
        check("h_win", 84'(bus.win_found), 84'd1);
        tick(8'(1 << S_SW));
        check("h_win_player_held", 84'(bus.current_player), 84'd1);
        tick(8'(1 << S_LEFT));
        check("h_win_cursor_held", 84'(bus.cursor_col), 84'd3);

        // Column 5 filled, then a rejected move
        tick(8'(1 << S_CLR));
        for (int i = 0; i < 6; i++) play(5, (i % 2) + 1);
        tick(8'(1 << S_VAL));
        check("col5_full", 84'(bus.column_full), 84'd1);
        tick(8'(1 << S_FIND));
        tick(8'(1 << S_DROP));
        tick(8'(1 << S_UPD));
        v = bus.disp_cells;
        check("col5_top", 84'(v[80 +: 2]), 84'd2);
        check("col5_nowin", 84'(bus.win_found), 84'd0);

        // Rising diagonal (0,0)..(3,3) for P1
        tick(8'(1 << S_CLR));
        for (int i = 0; i < 13; i++) play(dcols[i], (i % 2) + 1);
`ifdef CONNECT_FOUR_DIAG_WIN_EN
        check("diag_win", 84'(bus.win_found), 84'd1);
`else
        check("diag_win", 84'(bus.win_found), 84'd0);
`endif

        // Full board with no four-in-line anywhere
        tick(8'(1 << S_CLR));
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                play(c, (((c % 2) ^ ((r / 2) % 2)) != 0) ? 2 : 1);
        check("full_flag", 84'(bus.board_full), 84'd1);
        check("full_nowin", 84'(bus.win_found), 84'd0);
        tick(8'(1 << S_LEFT));
        check("full_cursor_held", 84'(bus.cursor_col), 84'd6);
        tick(8'(1 << S_VAL));
        check("full_col6", 84'(bus.column_full), 84'd1);

        // Reset in the middle of a move
        tick(8'(1 << S_CLR));
        play(2, 1);
        tick(8'(1 << S_UPD));
        move_to(4);
        tick(8'(1 << S_VAL));
        tick(8'(1 << S_FIND));
        #2;
        reset_edge = 1'b1;
        model_clear(1'b1);
        #1;
        check("mid_rst_disp", bus.disp_cells, 84'd0);
        check("mid_rst_cursor", 84'(bus.cursor_col), 84'd3);
        check("mid_rst_player", 84'(bus.current_player), 84'd1);
        bus.drop_token = 1'b1;
        @(posedge clk);
        #1;
        reset_edge = 1'b0;
        bus.drop_token = 1'b0;
        tick(8'(1 << S_DROP));
        tick(8'(1 << S_UPD));
        check("mid_rst_board_empty", bus.disp_cells, 84'd0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/connect_four_datapath.md
CONNECT_FOUR_DATAPATH -- requirements
Module: connect_four_datapath

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; reset_edge  in  1  asynchronous active-high reset.
REQ-002 SHALL have strobe inputs, each 1 bit, one cycle wide: clear_board, validate_enable, find_row_enable, drop_token, switch_player_enable, update_display.
REQ-003 SHALL have cursor inputs: move_left_edge  in  1  shift cursor left; move_right_edge  in  1  shift cursor right.
REQ-004 SHALL have outputs: column_full  out  1  target column full; win_found  out  1  last drop made four-in-line; board_full  out  1  all 42 cells occupied; current_player  out  2  01=P1, 10=P2.
REQ-005 SHALL have outputs: cursor_col  out  3  selected column 0..6; disp_cells  out  84  display snapshot, 2 bits/cell, index (row*7+col)*2, row 0 = bottom.

Function
REQ-006 SHALL hold the board as 6x7 cells (00 EMPTY, 01 P1, 10 P2), per-column height counters 0..6, and a piece counter 0..42.
REQ-007 SHALL sequence moves with a 3-state FSM: IDLE, VALIDATED, ROW_READY.
REQ-008 validate_enable SHALL latch target_col <= cursor_col and register column_full <= (height[cursor_col]==6), valid the next cycle, in any state.
REQ-009 After validate_enable, FSM SHALL go to VALIDATED if the column is not full, else to IDLE.
REQ-010 find_row_enable in VALIDATED SHALL latch target_row <= height[target_col] and go to ROW_READY; elsewhere it SHALL be ignored.
REQ-011 drop_token in ROW_READY SHALL, in one edge: write current_player to [target_row][target_col]; increment the height and the piece counter; register win_found and board_full; return to IDLE.
REQ-012 drop_token outside ROW_READY SHALL be ignored, with no board write.
REQ-013 win_found SHALL be 1 when, with the new token, any checked direction pair through the placed cell gives 1 + run(+dir) + run(-dir) >= 4. Runs are capped at 3 and stay on the board.
REQ-014 board_full SHALL be 1 when the piece counter reaches 42.
REQ-015 win_found and board_full SHALL be sticky until clear_board or reset.
REQ-016 switch_player_enable SHALL toggle current_player 01<->10, unless win_found=1, in which case the player is held.
REQ-017 move_left_edge and move_right_edge SHALL saturate cursor_col at 0 and 6.
REQ-018 If both move edges arrive in the same cycle, or win_found|board_full=1, cursor_col SHALL NOT change.
REQ-019 update_display SHALL copy the board into the disp_cells register, visible the next cycle; disp_cells SHALL NOT change otherwise.
REQ-020 clear_board SHALL set: all cells EMPTY; heights 0; piece counter 0; column_full, win_found, board_full 0; current_player 01; cursor_col 3; FSM IDLE. disp_cells SHALL be unchanged.
REQ-021 clear_board SHALL take priority over every other strobe in the same cycle.
REQ-022 Between the other strobes, the priority order SHALL be drop_token > find_row_enable > validate_enable.

Reset
REQ-023 reset_edge SHALL asynchronously force the state of REQ-020 and also disp_cells = 0.
REQ-024 Asserting reset_edge mid-move (VALIDATED or ROW_READY) SHALL abort the move, with no board write.

Configuration
REQ-025 With CONNECT_FOUR_DIAG_WIN_EN defined, the win check SHALL cover horizontal, vertical and both diagonals.
REQ-026 Without CONNECT_FOUR_DIAG_WIN_EN, the win check SHALL cover horizontal and vertical only, and no diagonal logic SHALL be synthesized.

Structure
REQ-027 Package connect_four_pkg SHALL hold ROWS=6, COLS=7, cell_t (EMPTY/P1/P2), dp_state_t and the player encodings.
REQ-028 Sub-module connect_four_win_check SHALL be combinational. Inputs: board, row, col, player. Output: win.
REQ-029 Each direction run in connect_four_win_check SHALL be computed by a function in the package.

Verification
REQ-030 Clear, then 4x (validate/find_row/drop/switch) all in column 3 -> height[3]=4, win_found=0; P1/P2 alternate at rows 0..3.
REQ-031 P1 at cols 0,1,2,3 row 0 (P2 elsewhere) -> win_found=1 one cycle after the 4th drop; switch_player_enable then leaves current_player=01.
REQ-032 Fill column 5 to 6 tokens, then validate -> column_full=1 and FSM IDLE; a following drop_token leaves the board unchanged.
REQ-033 Diagonal P1 at (0,0),(1,1),(2,2),(3,3) -> win_found=1 with CONNECT_FOUR_DIAG_WIN_EN defined, 0 without.
REQ-034 Fill all 42 cells with no four-in-line -> board_full=1, win_found=0; cursor moves are then ignored.
REQ-035 Assert reset_edge while in ROW_READY -> no cell written, cursor_col=3, current_player=01, disp_cells=0.
